lockstep_compare: RTL

Parametrised lockstep checker placed between a primary core and its shadow (re-implemented) core that share all inputs. The primary core's output bus is forwarded unchanged to the system. In parallel, the block compares both buses under a per-bit mask after a configurable hold-off, and counts mismatches. It latches a sticky trip flag and captures the first divergence for debug.

---
 rtl/lockstep_pkg.sv | 21 ++
 rtl/lockstep_sat_counter.sv | 38 +++
 rtl/lockstep_compare.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep comparator: state encoding and helpers.
package lockstep_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_TRIP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD,
        RUN  = ST_RUN,
        TRIP = ST_TRIP
    } state_e;

    // RUN and TRIP both sample and count; only RUN captures.
    function automatic logic is_comparing(input state_e s);
        return (s == RUN) || (s == TRIP);
    endfunction

endpackage

// File: rtl/lockstep_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module lockstep_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: clear wins, otherwise increment until saturated
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lockstep_compare.sv
// Lockstep checker: forwards a_bus, compares it against b_bus under mask after a hold-off.
// Optional first-divergence capture is built only when LOCKSTEP_CAPTURE_EN is defined.
module lockstep_compare
    import lockstep_pkg::*;
#(
    parameter int WIDTH   = 270,
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             clear,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] out_bus,
    output logic             mismatch,
    output logic             tripped,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] first_cycle,
    output logic [WIDTH-1:0] first_diff,
    output logic [1:0]       state
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;

    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              mismatch_q;
    logic              mismatch_d;
    logic [WIDTH-1:0]  diff_s;
    logic              hit_s;
    logic              cmp_s;

    assign out_bus = a_bus;
    assign diff_s  = (a_bus ^ b_bus) & mask;
    assign hit_s   = |diff_s;
    assign cmp_s   = is_comparing(state_q);

    // next state, hold-off counter and mismatch pulse
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        mismatch_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        hold_d  = '0;
                        state_d = (HOLDOFF == 0) ? RUN : HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_LAST) begin
                        state_d = RUN;
                    end else begin
                        state_d = HOLD;
                    end
                end
                RUN: begin
                    mismatch_d = hit_s;
                    state_d    = hit_s ? TRIP : RUN;
                end
                TRIP: begin
                    mismatch_d = hit_s;
                    state_d    = TRIP;
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            mismatch_q <= mismatch_d;
        end
    end

    lockstep_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (cmp_s),
        .count (cycle_count)
    );

    lockstep_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (cmp_s & hit_s),
        .count (err_count)
    );

`ifdef LOCKSTEP_CAPTURE_EN
    logic [CNT_W-1:0] first_cycle_q;
    logic [CNT_W-1:0] first_cycle_d;
    logic [WIDTH-1:0] first_diff_q;
    logic [WIDTH-1:0] first_diff_d;

    // capture only on the RUN->TRIP edge, so the first divergence is frozen
    always_comb begin
        first_cycle_d = first_cycle_q;
        first_diff_d  = first_diff_q;
        if (clear) begin
            first_cycle_d = '0;
            first_diff_d  = '0;
        end else if ((state_q == RUN) && hit_s) begin
            first_cycle_d = cycle_count;
            first_diff_d  = diff_s;
        end else begin
            first_cycle_d = first_cycle_q;
            first_diff_d  = first_diff_q;
        end
    end

    // capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_cycle_q <= '0;
            first_diff_q  <= '0;
        end else begin
            first_cycle_q <= first_cycle_d;
            first_diff_q  <= first_diff_d;
        end
    end

    assign first_cycle = first_cycle_q;
    assign first_diff  = first_diff_q;
`else
    assign first_cycle = '0;
    assign first_diff  = '0;
`endif

    assign mismatch = mismatch_q;
    assign tripped  = (state_q == TRIP);
    assign state    = state_q;

endmodule
